// File: rtl/slow_ctrl_pkg.sv
// Shared definitions for the slow-counter rate/burst controller:
// state encoding and default field widths.
package slow_ctrl_pkg;

    // Default width of the period field (period = div + 1 clocks)
    localparam int DIV_W_DEF = 8;
    // Default width of burst length / remaining-ticks fields (matches counter q)
    localparam int CNT_W_DEF = 4;

    // Controller states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : slow_ctrl_pkg

// File: rtl/slow_counter_ctrl_if.sv
// Configuration handshake bundle for slow_counter_ctrl.
// The master (control logic) offers a period/length pair with cfg_valid;
// the slave (controller) raises cfg_ready while it is idle.
interface slow_counter_ctrl_if #(
    parameter int DIV_W = slow_ctrl_pkg::DIV_W_DEF,
    parameter int CNT_W = slow_ctrl_pkg::CNT_W_DEF
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_len;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_len,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_len,
        output cfg_ready
    );

endinterface : slow_counter_ctrl_if

// File: rtl/slow_ctrl_prescaler.sv
// Period down-counter for slow_counter_ctrl.
// Synchronous load has priority over the count enable; tc flags a zero count,
// at which point the owner is expected to reload rather than let it wrap.
module slow_ctrl_prescaler
    import slow_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] load_val,
    output logic [DIV_W-1:0] count,
    output logic             tc
);

    localparam logic [DIV_W-1:0] COUNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    // Count register: reset to zero, load wins over decrement, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count - COUNT_ONE;
        end else begin
            count <= count;
        end
    end

    assign tc = (count == '0);

endmodule : slow_ctrl_prescaler

// File: rtl/slow_counter_ctrl.sv
// Rate and burst controller driving the slow-counter enable.
// A handshake in IDLE latches a period (cfg_div+1 clocks) and a burst length
// (cfg_len, 0 = free-run); RUN then emits one-cycle `slow` strobes every period
// until the burst completes (done pulse) or stop is asserted.
// Optional build macro SLOW_CTRL_PAUSE_EN adds a `pause` input that freezes the
// period count and burst count while held; without it the controller behaves
// as if pause were tied low.
module slow_counter_ctrl
    import slow_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SLOW_CTRL_PAUSE_EN
    input  logic             pause,
`endif
    slow_counter_ctrl_if.slave cfg,
    input  logic             stop,
    output logic             slow,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] ticks_left
);

    localparam logic [CNT_W-1:0] TICK_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [DIV_W-1:0] div_r;
    logic             free_run_r;

    logic             pause_s;
    logic             accept_s;
    logic             advance_s;
    logic             strobe_s;
    logic             pre_load_s;
    logic [DIV_W-1:0] pre_load_val_s;
    logic [DIV_W-1:0] pre_count_s;
    logic             pre_tc_s;

`ifdef SLOW_CTRL_PAUSE_EN
    assign pause_s = pause;
`else
    assign pause_s = 1'b0;
`endif

    // Ready whenever idle; this is the only combinational output
    assign cfg.cfg_ready = (state_r == ST_IDLE);

    // Handshake and advance qualifiers: stop beats pause, pause beats a due strobe
    always_comb begin
        accept_s  = 1'b0;
        advance_s = 1'b0;
        if (state_r == ST_IDLE) begin
            accept_s = cfg.cfg_valid;
        end else if (!stop && !pause_s) begin
            advance_s = 1'b1;
        end else begin
            advance_s = 1'b0;
        end
        strobe_s = advance_s && pre_tc_s;
    end

    // Prescaler control: load the new period on accept, reload on each strobe
    always_comb begin
        pre_load_s     = 1'b0;
        pre_load_val_s = div_r;
        if (accept_s) begin
            pre_load_s     = 1'b1;
            pre_load_val_s = cfg.cfg_div;
        end else if (strobe_s) begin
            pre_load_s     = 1'b1;
            pre_load_val_s = div_r;
        end else begin
            pre_load_s     = 1'b0;
            pre_load_val_s = div_r;
        end
    end

    slow_ctrl_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .load     (pre_load_s),
        .en       (advance_s),
        .load_val (pre_load_val_s),
        .count    (pre_count_s),
        .tc       (pre_tc_s)
    );

    // Controller FSM with registered strobe, status and burst countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            div_r      <= '0;
            free_run_r <= 1'b0;
            slow       <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            ticks_left <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    slow <= 1'b0;
                    done <= 1'b0;
                    if (accept_s) begin
                        state_r    <= ST_RUN;
                        div_r      <= cfg.cfg_div;
                        free_run_r <= (cfg.cfg_len == '0);
                        ticks_left <= cfg.cfg_len;
                        busy       <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    done <= 1'b0;
                    if (stop) begin
                        // Abort: no strobe, no done, ticks_left keeps its value
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        slow    <= 1'b0;
                    end else if (strobe_s) begin
                        slow <= 1'b1;
                        if (!free_run_r) begin
                            ticks_left <= ticks_left - TICK_ONE;
                            if (ticks_left == TICK_ONE) begin
                                // Last strobe of the burst completes on this edge
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                state_r <= ST_IDLE;
                            end else begin
                                busy <= 1'b1;
                            end
                        end else begin
                            busy <= 1'b1;
                        end
                    end else begin
                        slow <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    slow    <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : slow_counter_ctrl
